// File: rtl/flow_control.sv
// flow_control
// Per-direction ready gate between the input FIFOs and the five router output
// directions (N, E, W, S, L). Each channel registers the AND of "a flit is
// routed toward X" and "the X output side can accept data". The result is
// returned to the input side as Xready_out. The five channels are identical
// and independent.
//
// Ports
//   clk                      router clock, rising-edge
//   rst                      asynchronous reset, active low
//   Nport..Lport             a flit is currently routed toward that output
//   Lready_in..Sready_in     that output side can accept data
//   Lready_out..Sready_out   input side may send toward that output (registered)
module flow_control (
    input  logic clk,
    input  logic rst,
    input  logic Nport,
    input  logic Eport,
    input  logic Wport,
    input  logic Sport,
    input  logic Lport,
    input  logic Lready_in,
    input  logic Nready_in,
    input  logic Eready_in,
    input  logic Wready_in,
    input  logic Sready_in,
    output logic Lready_out,
    output logic Nready_out,
    output logic Eready_out,
    output logic Wready_out,
    output logic Sready_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Nready_out <= 1'b0;
            Eready_out <= 1'b0;
            Wready_out <= 1'b0;
            Sready_out <= 1'b0;
            Lready_out <= 1'b0;
        end else begin
            Nready_out <= Nport & Nready_in;
            Eready_out <= Eport & Eready_in;
            Wready_out <= Wport & Wready_in;
            Sready_out <= Sport & Sready_in;
            Lready_out <= Lport & Lready_in;
        end
    end

endmodule

// File: tb/tb_flow_control.sv
// tb_flow_control
// Directed bench for flow_control. Inputs and outputs are grouped here as
// 5-bit vectors ordered {N, E, W, S, L}. Every expected value is written as a
// constant, or is derived from the loop indices of a directed sweep.
module tb_flow_control;

    logic clk;
    logic rst;
    logic Nport, Eport, Wport, Sport, Lport;
    logic Lready_in, Nready_in, Eready_in, Wready_in, Sready_in;
    logic Lready_out, Nready_out, Eready_out, Wready_out, Sready_out;

    logic [4:0] outs;
    int checks = 0;
    int errors = 0;

    flow_control dut (
        .clk        (clk),
        .rst        (rst),
        .Nport      (Nport),
        .Eport      (Eport),
        .Wport      (Wport),
        .Sport      (Sport),
        .Lport      (Lport),
        .Lready_in  (Lready_in),
        .Nready_in  (Nready_in),
        .Eready_in  (Eready_in),
        .Wready_in  (Wready_in),
        .Sready_in  (Sready_in),
        .Lready_out (Lready_out),
        .Nready_out (Nready_out),
        .Eready_out (Eready_out),
        .Wready_out (Wready_out),
        .Sready_out (Sready_out)
    );

    assign outs = {Nready_out, Eready_out, Wready_out, Sready_out, Lready_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // ports and rdys are ordered {N, E, W, S, L}
    task automatic apply(input logic [4:0] ports, input logic [4:0] rdys);
        {Nport, Eport, Wport, Sport, Lport} = ports;
        {Nready_in, Eready_in, Wready_in, Sready_in, Lready_in} = rdys;
    endtask

    // advance past the next rising edge; sampling happens 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] chan;
        string names [5];
        names = '{"N", "E", "W", "S", "L"};

        rst = 1'b0;
        apply(5'b00000, 5'b00000);
        #2;
        check_val("reset_initial", outs, 5'b00000);
        step();
        check_val("reset_held", outs, 5'b00000);

        // release reset; the first edge with rst high samples the inputs
        apply(5'b11111, 5'b11111);
        rst = 1'b1;
        step();
        check_val("release_all_ones", outs, 5'b11111);

        // asynchronous assert mid-cycle
        #3;
        rst = 1'b0;
        #1;
        check_val("async_reset_immediate", outs, 5'b00000);
        step();
        check_val("reset_held_over_edge", outs, 5'b00000);
        rst = 1'b1;
        step();
        check_val("release_no_dead_cycle", outs, 5'b11111);

        // per-channel 2-bit sweep: only {port,ready}=11 raises that channel
        for (int c = 0; c < 5; c++) begin
            chan = 5'b10000 >> c;
            for (int p = 0; p < 4; p++) begin
                apply((p >= 2) ? chan : 5'b00000, (p % 2 == 1) ? chan : 5'b00000);
                step();
                check_val($sformatf("sweep_%s_%0d%0d", names[c], p / 2, p % 2),
                          outs, (p == 3) ? chan : 5'b00000);
            end
        end

        // back-pressure on Local, including one-cycle latency
        apply(5'b00001, 5'b00001);
        step();
        check_val("bp_L_ready1", outs, 5'b00001);
        apply(5'b00001, 5'b00000);
        #1;
        check_val("bp_L_before_edge", outs, 5'b00001);
        step();
        check_val("bp_L_ready0", outs, 5'b00000);
        apply(5'b00001, 5'b00001);
        #1;
        check_val("bp_L_latency", outs, 5'b00000);
        step();
        check_val("bp_L_ready1_again", outs, 5'b00001);

        // concurrency: N granted, E back-pressured
        apply(5'b11000, 5'b10000);
        step();
        check_val("concurrent_N1_E0", outs, 5'b10000);

        // several channels together, mixed
        apply(5'b10111, 5'b11101);
        step();
        check_val("concurrent_mixed", outs, 5'b10101);

        // inputs present during reset do not leak afterward
        rst = 1'b0;
        apply(5'b11111, 5'b11111);
        step();
        check_val("reset_ignores_inputs", outs, 5'b00000);
        apply(5'b00000, 5'b11111);
        rst = 1'b1;
        step();
        check_val("post_reset_no_residue", outs, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_control.md
# flow_control

Per-direction flow-control gate between a router's input FIFOs and its five output directions (North, East, West, South, Local). For each direction it combines "an input FIFO is routing to this direction" with "the downstream output side can accept data" into a registered ready signal back to the input side. The input FIFO stops forwarding data toward a direction whose output is not ready. The block sits between the crossbar/switch-allocation logic and the input FIFO read-enable logic.

## Interface
- No parameters.
- clk  in  1  router clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- Nport  in  1  a flit is currently routed toward the North output.
- Eport  in  1  a flit is currently routed toward the East output.
- Wport  in  1  a flit is currently routed toward the West output.
- Sport  in  1  a flit is currently routed toward the South output.
- Lport  in  1  a flit is currently routed toward the Local output.
- Lready_in  in  1  Local output side can accept data.
- Nready_in  in  1  North output side can accept data.
- Eready_in  in  1  East output side can accept data.
- Wready_in  in  1  West output side can accept data.
- Sready_in  in  1  South output side can accept data.
- Lready_out  out  1  input side may send data toward Local.
- Nready_out  out  1  input side may send data toward North.
- Eready_out  out  1  input side may send data toward East.
- Wready_out  out  1  input side may send data toward West.
- Sready_out  out  1  input side may send data toward South.
- Positional port order after clk: rst, Nport, Eport, Wport, Sport, Lport, Lready_in, Nready_in, Eready_in, Wready_in, Sready_in, Lready_out, Nready_out, Eready_out, Wready_out, Sready_out.

## Operation
- Five independent, identical channels (X ∈ {N, E, W, S, L}); no interaction or arbitration between channels.
- Per channel, on each rising clk edge with rst high: Xready_out <= Xport & Xready_in.
- Xport=0: Xready_out goes to 0 on the next edge, regardless of Xready_in.
- Xport=1, Xready_in=0: Xready_out goes to 0 on the next edge. Back-pressure: the input FIFO must not send toward X.
- Xport=1, Xready_in=1: Xready_out goes to 1 on the next edge.
- No other state. The outputs are purely a registered image of the AND of each port/ready pair.

## Timing
- Reset: rst=0 forces all five Xready_out to 0 immediately (asynchronous), independent of clk. Outputs stay 0 while rst=0.
- Reset release: the first rising edge with rst=1 samples the inputs normally. There is no extra dead cycle.
- Latency: exactly 1 clk cycle from an input change to the corresponding Xready_out change.
- Reset mid-operation: any Xready_out at 1 drops to 0 asynchronously. Inputs present during reset have no effect afterward.
- Simultaneous activity on multiple channels is allowed. Each channel updates in the same cycle, independently.
- Inputs are assumed synchronous to clk. No input synchronizers.

## Test plan
- Reset: drive all inputs to 1, then pulse rst=0 mid-cycle -> all five ready_out = 0 immediately and while rst=0; after release, next edge -> all ready_out = 1.
- North sweep: {Nport,Nready_in} = 00, 01, 10, 11, one cycle each -> Nready_out one cycle later = 0, 0, 0, 1; the other four outputs stay 0.
- Repeat the 2-bit sweep for E, W, S and L -> only the exercised channel's ready_out rises, and only in the 11 case, 1 cycle after it is applied.
- Back-pressure: hold Lport=1 and toggle Lready_in 1→0→1 on successive cycles -> Lready_out follows 1→0→1, delayed by one cycle.
- Concurrency: Nport=Eport=1, Nready_in=1, Eready_in=0 -> next edge Nready_out=1, Eready_out=0; W/S/L outputs = 0.
